// File: rtl/dbgmon_trace_dump_pkg.sv
// Shared debug-monitor definitions.
// Trace dump sequencer states and trace window geometry.
package dbgmon_trace_dump_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        OUT,
        DONE
    } dbgmon_dump_state_e;

    localparam int          DBGMON_TRACE_WORDS   = 8;
    localparam int          DBGMON_TRACE_ENTRIES = 128;
    localparam logic [12:0] DBGMON_TRACE_WIN     = 13'h0000;

endpackage

// File: rtl/dbgmon_trace_dump_if.sv
// APB master bus plus outbound word stream of the trace dumper.
// master = dumper side, slave = monitor/bridge side.
interface dbgmon_trace_dump_if;

    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    logic        m_valid;
    logic [31:0] m_data;
    logic [2:0]  m_word;
    logic        m_last;
    logic        m_ready;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr,
        output m_valid, m_data, m_word, m_last,
        input  m_ready
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr,
        input  m_valid, m_data, m_word, m_last,
        output m_ready
    );

endinterface

// File: rtl/dbgmon_trace_dump.sv
// Drains the debug-monitor trace buffer over APB, one read per word,
// and forwards each word on a valid/ready stream.
module dbgmon_trace_dump
    import dbgmon_trace_dump_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR       = 32'h0,
    parameter int          ENTRY_AW        = 7,
    parameter int          WORDS_PER_ENTRY = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [ENTRY_AW-1:0] start_idx,
    input  logic [7:0]          entry_cnt,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                aborted,
    dbgmon_trace_dump_if.master bus
);

    dbgmon_dump_state_e state_q, state_d;

    logic [ENTRY_AW-1:0] idx_q;
    logic [2:0]          word_q;
    logic [10:0]         wcnt_q;
    logic [10:0]         total_q;
    logic [31:0]         data_q;
    logic [2:0]          mword_q;
    logic                last_q;
    logic                abort_pend_q;

    logic                abort_req;
    logic [10:0]         n_ent;
    logic [12:0]         win_off;

    // An abort seen anywhere in a transfer is honoured at the next safe point.
    assign abort_req = abort | abort_pend_q;

    assign n_ent = (entry_cnt == 8'd0) ?
                   11'(DBGMON_TRACE_ENTRIES) :
                   {3'b000, entry_cnt};

    assign win_off = DBGMON_TRACE_WIN |
                     13'({idx_q, word_q, 2'b00});

    assign bus.paddr  = BASE_ADDR + {19'd0, win_off};
    assign bus.pwrite = 1'b0;
    assign bus.pwdata = 32'd0;
    assign bus.m_data = data_q;
    assign bus.m_word = mword_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_d     = state_q;
        busy        = 1'b1;
        done        = 1'b0;
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        bus.m_valid = 1'b0;
        bus.m_last  = 1'b0;
        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) state_d = SETUP;
            end
            SETUP: begin
                bus.psel = 1'b1;
                state_d  = ACCESS;
            end
            ACCESS: begin
                bus.psel    = 1'b1;
                bus.penable = 1'b1;
                if (bus.pready) begin
                    if (bus.pslverr || abort_req) state_d = DONE;
                    else                          state_d = OUT;
                end
            end
            OUT: begin
                bus.m_valid = 1'b1;
                bus.m_last  = last_q;
                if (bus.m_ready) begin
                    if (last_q || abort_req) state_d = DONE;
                    else                     state_d = SETUP;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Address counters, captured stream word and sticky status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q        <= '0;
            word_q       <= '0;
            wcnt_q       <= '0;
            total_q      <= '0;
            data_q       <= '0;
            mword_q      <= '0;
            last_q       <= 1'b0;
            err          <= 1'b0;
            aborted      <= 1'b0;
            abort_pend_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    abort_pend_q <= 1'b0;
                    if (start) begin
                        idx_q   <= start_idx;
                        word_q  <= '0;
                        wcnt_q  <= '0;
                        total_q <= 11'(n_ent * WORDS_PER_ENTRY);
                        err     <= 1'b0;
                        aborted <= 1'b0;
                    end
                end
                SETUP: begin
                    if (abort) abort_pend_q <= 1'b1;
                end
                ACCESS: begin
                    if (abort) abort_pend_q <= 1'b1;
                    if (bus.pready) begin
                        if (bus.pslverr) begin
                            err <= 1'b1;
                        end else if (abort_req) begin
                            aborted <= 1'b1;
                        end else begin
                            data_q  <= bus.prdata;
                            mword_q <= word_q;
                            last_q  <= (wcnt_q == total_q - 11'd1);
                        end
                    end
                end
                OUT: begin
                    if (abort) abort_pend_q <= 1'b1;
                    if (bus.m_ready) begin
                        wcnt_q <= wcnt_q + 11'd1;
                        word_q <= word_q + 3'd1;
                        if (word_q == 3'(WORDS_PER_ENTRY - 1))
                            idx_q <= idx_q + ENTRY_AW'(1);
                        if (!last_q && abort_req) aborted <= 1'b1;
                    end
                end
                DONE: begin
                    abort_pend_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dbgmon_trace_dump.sv
// Scoreboard bench for the trace dumper: APB slave model, stream sink
// and abort driver run beside a stimulus process that queues expectations.
module tb_dbgmon_trace_dump;

    localparam logic [31:0] BASE = 32'h0;

    typedef struct {
        logic [31:0] data;
        logic [2:0]  word;
        logic        last;
    } sw_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [6:0] start_idx = '0;
    logic [7:0] entry_cnt = '0;
    logic       busy, done, err, aborted;

    dbgmon_trace_dump_if bus();

    dbgmon_trace_dump #(.BASE_ADDR(BASE)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .start_idx (start_idx),
        .entry_cnt (entry_cnt),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .aborted   (aborted),
        .bus       (bus.master)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    sw_t         exp_s[$];
    logic [31:0] exp_a[$];
    logic [31:0] salt = '0;
    int          wait_cfg = 0;
    int          stall_cfg = 0;
    bit          err_en = 1'b0;
    logic [31:0] err_addr = '0;
    int          abort_mode = 0;
    logic [31:0] abort_addr = '0;
    logic [2:0]  abort_word = '0;
    int          last_hs_cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Reference address of the i-th word of a dump starting at entry s.
    function automatic logic [31:0] waddr(input logic [6:0] s, input int i);
        int e;
        e = (int'(s) + i / 8) % 128;
        return BASE + 32'(e * 32) + 32'((i % 8) * 4);
    endfunction

    // APB slave: optional wait states, data = address ^ salt.
    int          wait_left = 0;
    logic [31:0] setup_addr = '0;
    always @(negedge clk) begin
        if (rst) begin
            bus.pready  = 1'b0;
            bus.pslverr = 1'b0;
            bus.prdata  = '0;
            wait_left   = 0;
        end else if (bus.psel && !bus.penable) begin
            bus.pready  = 1'b0;
            bus.pslverr = 1'b0;
            setup_addr  = bus.paddr;
            wait_left   = (wait_cfg < 0) ?
                          int'($urandom_range(0, 2)) : wait_cfg;
        end else if (bus.psel && bus.penable) begin
            chk("paddr_hold", bus.paddr, setup_addr);
            if (wait_left > 0) begin
                bus.pready = 1'b0;
                wait_left--;
            end else begin
                bus.pready  = 1'b1;
                bus.prdata  = bus.paddr ^ salt;
                bus.pslverr = err_en && (bus.paddr == err_addr);
                chk("pwrite", 32'(bus.pwrite), 32'd0);
                if (exp_a.size() == 0)
                    chk("apb_extra_read", bus.paddr, 32'hFFFF_FFFF);
                else
                    chk("apb_addr", bus.paddr, exp_a.pop_front());
            end
        end else begin
            bus.pready  = 1'b0;
            bus.pslverr = 1'b0;
        end
    end

    // Stream sink: holds off m_ready per word and checks each handshake.
    bit  in_word = 1'b0;
    int  hold_left = 0;
    sw_t snap;
    sw_t e;
    always @(negedge clk) begin
        if (rst) begin
            bus.m_ready = 1'b0;
            in_word     = 1'b0;
            hold_left   = 0;
        end else if (bus.m_valid) begin
            if (!in_word) begin
                in_word   = 1'b1;
                snap.data = bus.m_data;
                snap.word = bus.m_word;
                snap.last = bus.m_last;
                if (abort_mode == 2 && bus.m_word == abort_word)
                    hold_left = 5;
                else if (stall_cfg < 0)
                    hold_left = int'($urandom_range(0, 3));
                else
                    hold_left = stall_cfg;
            end else begin
                chk("m_data_hold", bus.m_data, snap.data);
                chk("m_word_hold", 32'(bus.m_word), 32'(snap.word));
                chk("m_last_hold", 32'(bus.m_last), 32'(snap.last));
            end
            chk("psel_in_out", 32'(bus.psel), 32'd0);
            if (hold_left > 0) begin
                bus.m_ready = 1'b0;
                hold_left--;
            end else begin
                bus.m_ready = 1'b1;
                in_word     = 1'b0;
                if (bus.m_last) last_hs_cyc = cyc + 1;
                if (exp_s.size() == 0) begin
                    chk("stream_extra", bus.m_data, 32'hFFFF_FFFF);
                end else begin
                    e = exp_s.pop_front();
                    chk("m_data", bus.m_data, e.data);
                    chk("m_word", 32'(bus.m_word), 32'(e.word));
                    chk("m_last", 32'(bus.m_last), 32'(e.last));
                end
            end
        end else begin
            bus.m_ready = 1'($urandom_range(0, 1));
        end
    end

    // Abort driver: 1 = pulse in SETUP of abort_addr,
    // 2 = hold from OUT of abort_word, 3 = high only while idle.
    always @(negedge clk) begin
        if (rst) begin
            abort = 1'b0;
        end else if (abort_mode == 1) begin
            abort = bus.psel && !bus.penable &&
                    (bus.paddr == abort_addr);
        end else if (abort_mode == 2) begin
            abort = abort ||
                    (bus.m_valid && bus.m_word == abort_word);
        end else if (abort_mode == 3) begin
            abort = !busy;
        end else begin
            abort = 1'b0;
        end
    end

    task automatic run(input logic [6:0] sidx, input logic [7:0] ecnt,
                       input int err_at, input int amode, input int aat,
                       input int wcfg, input int scfg,
                       input bit chk_lat, input bit restart);
        int  n, reads, emits, budget, st_cyc;
        bit  e_err, e_ab, got;
        sw_t t;
        n      = (ecnt == 8'd0) ? 1024 : int'(ecnt) * 8;
        reads  = n;
        emits  = n;
        e_err  = 1'b0;
        e_ab   = 1'b0;
        if (err_at >= 0) begin
            reads = err_at + 1; emits = err_at; e_err = 1'b1;
        end else if (amode == 1) begin
            reads = aat + 1; emits = aat; e_ab = 1'b1;
        end else if (amode == 2) begin
            reads = aat + 1; emits = aat + 1; e_ab = (aat != n - 1);
        end
        salt = $urandom;
        for (int i = 0; i < reads; i++) exp_a.push_back(waddr(sidx, i));
        for (int i = 0; i < emits; i++) begin
            t.data = waddr(sidx, i) ^ salt;
            t.word = 3'(i % 8);
            t.last = (i == n - 1);
            exp_s.push_back(t);
        end
        err_en     = (err_at >= 0);
        err_addr   = waddr(sidx, (err_at >= 0) ? err_at : 0);
        abort_addr = waddr(sidx, aat);
        abort_word = 3'(aat % 8);
        wait_cfg   = wcfg;
        stall_cfg  = scfg;
        @(negedge clk);
        abort_mode = amode;
        start_idx  = sidx;
        entry_cnt  = ecnt;
        start      = 1'b1;
        st_cyc     = cyc + 1;
        @(negedge clk);
        start  = 1'b0;
        budget = n * 14 + 100;
        got    = 1'b0;
        for (int c = 0; c < budget && !got; c++) begin
            if (done) begin
                got = 1'b1;
            end else begin
                if (restart && c == 10) begin
                    start     = 1'b1;
                    start_idx = sidx + 7'd50;
                    entry_cnt = 8'd3;
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
            end
        end
        start = 1'b0;
        chk("done_seen", 32'(got), 32'd1);
        if (got) begin
            chk("err", 32'(err), 32'(e_err));
            chk("aborted", 32'(aborted), 32'(e_ab));
            if (chk_lat) begin
                chk("start_to_last", 32'(last_hs_cyc - st_cyc), 32'd24);
                chk("done_after_last", 32'(cyc), 32'(last_hs_cyc));
            end
            @(negedge clk);
            chk("done_pulse", 32'(done), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("err_sticky", 32'(err), 32'(e_err));
            chk("aborted_sticky", 32'(aborted), 32'(e_ab));
        end
        chk("apb_left", 32'(exp_a.size()), 32'd0);
        chk("stream_left", 32'(exp_s.size()), 32'd0);
        abort_mode = 0;
        err_en     = 1'b0;
        exp_a.delete();
        exp_s.delete();
        repeat (3) @(negedge clk);
    endtask

    initial begin : stim
        bit got;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_aborted", 32'(aborted), 32'd0);
        chk("rst_psel", 32'(bus.psel), 32'd0);
        chk("rst_penable", 32'(bus.penable), 32'd0);
        chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
        chk("rst_m_last", 32'(bus.m_last), 32'd0);
        chk("rst_paddr", bus.paddr, BASE);
        chk("rst_m_data", bus.m_data, 32'd0);
        chk("rst_pwdata", bus.pwdata, 32'd0);

        run(7'd0, 8'd1, -1, 0, 0, 0, 0, 1'b1, 1'b0);
        run(7'd126, 8'd3, -1, 0, 0, 0, 0, 1'b0, 1'b0);
        run(7'd5, 8'd2, -1, 0, 0, 3, 5, 1'b0, 1'b0);
        run(7'd9, 8'd2, 10, 0, 0, 0, 0, 1'b0, 1'b0);
        run(7'd20, 8'd1, -1, 1, 3, 0, 0, 1'b0, 1'b0);
        run(7'd40, 8'd2, -1, 2, 2, 0, 0, 1'b0, 1'b0);
        run(7'd64, 8'd2, -1, 3, 0, 0, 0, 1'b0, 1'b0);
        run(7'd3, 8'd2, -1, 0, 0, 0, 0, 1'b0, 1'b1);
        for (int k = 0; k < 6; k++)
            run(7'($urandom), 8'($urandom_range(1, 4)), -1, 0, 0,
                -1, -1, 1'b0, 1'($urandom_range(0, 1)));
        run(7'($urandom), 8'd0, -1, 0, 0, 0, 0, 1'b0, 1'b0);

        salt     = $urandom;
        wait_cfg = 50;
        for (int i = 0; i < 16; i++) exp_a.push_back(waddr(7'd10, i));
        @(negedge clk);
        start_idx = 7'd10;
        entry_cnt = 8'd2;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        got   = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            if (bus.psel && bus.penable) got = 1'b1;
            else @(negedge clk);
        end
        chk("reach_access", 32'(got), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_psel", 32'(bus.psel), 32'd0);
        chk("arst_penable", 32'(bus.penable), 32'd0);
        chk("arst_m_valid", 32'(bus.m_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        exp_a.delete();
        exp_s.delete();
        wait_cfg = 0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        run(7'd77, 8'd2, -1, 0, 0, 0, 0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dbgmon_trace_dump.md
Name: dbgmon_trace_dump

Overview:
- APB master sequencer that drains the debug-monitor trace buffer after a trace stop.
- On a start command it reads a range of 256-bit trace entries, one 32-bit APB read per word (8 words per entry), from the monitor's trace window (paddr[12]=0).
- It emits the words on a valid/ready stream toward the debug UART/JTAG bridge.
- It is the only master on the monitor's trace window while busy.

Parameters:
- BASE_ADDR, 32'h0, APB base address of the debug monitor; the trace window sits at offset 0x0000–0x0FFF.
- ENTRY_AW, 7, entry index width (128-entry trace buffer).
- WORDS_PER_ENTRY, 8, 32-bit words per trace entry; fixed, not meant to be overridden.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle command pulse; ignored unless state==IDLE
- abort  in  1  level/pulse; stop the sequence at the next safe point
- start_idx  in  7  first entry index, as used in paddr[11:5]
- entry_cnt  in  8  number of entries; 1..128, 0 means 128
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at end of sequence (normal, abort or error)
- err  out  1  sticky pslverr seen; cleared on accepted start
- aborted  out  1  sticky abort taken; cleared on accepted start
- psel, penable, pwrite  out  1 each  APB master controls; pwrite always 0
- paddr  out  32  APB address
- pwdata  out  32  tied 0
- prdata  in  32  APB read data
- pready, pslverr  in  1 each  APB response
- m_valid  out  1  stream word valid
- m_data  out  32  stream word
- m_word  out  3  word index within entry
- m_last  out  1  final word of the sequence
- m_ready  in  1  stream sink ready

Behaviour:
- Reset values: every output 0, state IDLE, counters 0.
- The accepted start latches:
  - idx = start_idx
  - wcnt = 0
  - total = (entry_cnt==0 ? 128 : entry_cnt) * 8, 11-bit, max 1024.
- It also clears err and aborted.
- paddr = BASE_ADDR + {idx, word[2:0], 2'b00}; zero-extended, 32-bit add, no carry check.
- idx wraps modulo 128: 127 → 0 after word 7.

FSM states: IDLE, SETUP, ACCESS, OUT, DONE.
- IDLE: on start → SETUP next cycle.
- SETUP: psel=1, penable=0, paddr valid; always → ACCESS after exactly 1 cycle.
- ACCESS: psel=1, penable=1, paddr held; stay while pready=0.
  - On pready & pslverr: set err, discard data → DONE.
  - On pready & abort (sampled that cycle): set aborted, discard data → DONE.
  - Otherwise capture prdata into m_data, set m_word=word, set m_last=(wcnt==total-1), set m_valid=1 → OUT.
- OUT: m_valid, m_data, m_word and m_last are held stable until m_ready.
  - On m_valid & m_ready: wcnt++ and word++; on word wrap, idx++.
  - If m_last → DONE.
  - Else if abort → set aborted, go DONE.
  - Else → SETUP.
  - abort never drops m_valid before the handshake completes.
- DONE: done=1 for one cycle, psel=0 → IDLE. start is ignored in DONE.
- psel/penable are deasserted in IDLE, OUT and DONE.
- Minimum throughput is 3 cycles per word when m_ready=1 and pready=1.
- abort in IDLE has no effect. abort in SETUP is deferred: the APB transfer always completes (protocol), then the ACCESS rule applies.
- rst asserted mid-transfer returns everything to reset values immediately; the APB slave tolerates the dropped psel.
- err and aborted remain valid after done until the next accepted start.

Decomposition:
- Add to the shared dbgmon package:
  - state enum dbgmon_dump_state_e (IDLE, SETUP, ACCESS, OUT, DONE)
  - localparams DBGMON_TRACE_WORDS=8, DBGMON_TRACE_ENTRIES=128, DBGMON_TRACE_WIN=13'h0000
- No sub-module is needed. The address generator and counters stay inline in one module of roughly 200 lines.

Test Plan:
- Basic dump: start_idx=0, entry_cnt=1, APB slave pready=1 returning prdata=paddr, m_ready=1.
  - Expect 8 reads at paddr 0x00..0x1C, in order.
  - Expect m_data=0x00..0x1C with m_word 0..7.
  - Expect m_last only on word 7, done 1 cycle later, 24 cycles start→last handshake.
- Wrap and full count: start_idx=126, entry_cnt=3 → paddr sequence 0xFC0.., 0xFE0.., 0x000..0x01C; 24 words. Separately, entry_cnt=0 → exactly 1024 words, m_last on the 1024th.
- Backpressure/wait states:
  - pready low 3 cycles on each read: paddr and penable stay stable through the wait.
  - m_ready low 5 cycles: m_valid/m_data stable, no new psel.
  - Data order is unchanged.
- Slave error: pslverr=1 on word 10 of a 2-entry dump → 10 words delivered, no 11th word, err=1, done pulse, m_last never asserted.
- Abort: abort pulsed during SETUP of word 3 → word 3 APB read completes but is not emitted, aborted=1, done pulse. Abort held during OUT with m_ready=0 → word held until m_ready, then done.
- Reset/start ignore: start while busy has no effect on counts. rst asserted in ACCESS → psel, m_valid and busy are 0 in the same cycle; a new start after release runs cleanly.
